comm_frame_tx: RTL and testbench

COMM_FRAME_TX -- requirements
Module: comm_frame_tx

---
 rtl/comm_frame_tx.sv | 130 +++++++++++++
 tb/tb_comm_frame_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/comm_frame_tx.sv
// Serial frame transmitter: handshakes NWORDS words of WL bits and shifts each
// out MSB first under an active-low chip select, with a divided serial clock.
module comm_frame_tx #(
  parameter int unsigned WL     = 16,
  parameter int unsigned NWORDS = 64,
  parameter int unsigned DIV    = 4
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic                              iCLR,
  input  logic                              iEN,
  input  logic                              iSTART,
  input  logic [WL-1:0]                     iDATA,
  input  logic                              iVALID,
  output logic                              oREADY,
  output logic                              oCSn,
  output logic                              oSCLK,
  output logic                              oSDATA,
  output logic                              oBUSY,
  output logic [$clog2(NWORDS+1)-1:0]       oWCNT,
  output logic                              oDONE
);

  localparam int unsigned CW = $clog2(NWORDS + 1);
  localparam int unsigned DW = $clog2(2 * DIV) + 1;
  localparam int unsigned BW = $clog2(WL) + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(DIV);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WL - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [WL-1:0] r_shreg;
  logic [DW-1:0] r_divcnt;
  logic [BW-1:0] r_bitcnt;
  logic [CW-1:0] r_wcnt;
  logic          r_sdata;
  logic          w_period_end;
  logic          w_word_end;

  assign w_period_end = (r_divcnt == DIV_LAST);
  assign w_word_end   = w_period_end && (r_bitcnt == BIT_LAST);

  // Outputs decode directly from held state, so iEN=0 freezes them for free.
  assign oREADY = (r_state == S_WAIT) && iEN && !iCLR;
  assign oBUSY  = (r_state != S_IDLE);
  assign oCSn   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign oSCLK  = (r_state == S_SHIFT) && (r_divcnt >= DIV_HALF);
  assign oDONE  = (r_state == S_DONE);
  assign oSDATA = r_sdata;
  assign oWCNT  = r_wcnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (iCLR) begin
      w_next = S_IDLE;
    end else if (iEN) begin
      case (r_state)
        S_IDLE:  if (iSTART) w_next = S_WAIT;
        S_WAIT:  if (iVALID) w_next = S_SHIFT;
        S_SHIFT: if (w_word_end) w_next = (r_wcnt == WORD_LAST) ? S_DONE : S_WAIT;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_shreg  <= '0;
      r_divcnt <= '0;
      r_bitcnt <= '0;
      r_wcnt   <= '0;
      r_sdata  <= 1'b0;
    end else if (iCLR) begin
      r_divcnt <= '0;
      r_bitcnt <= '0;
      r_wcnt   <= '0;
    end else if (iEN) begin
      case (r_state)
        S_IDLE: begin
          if (iSTART) r_wcnt <= '0;
        end
        S_WAIT: begin
          // MSB goes straight to the pin; the register keeps the remaining bits.
          if (iVALID) begin
            r_sdata  <= iDATA[WL-1];
            r_shreg  <= {iDATA[WL-2:0], 1'b0};
            r_divcnt <= '0;
            r_bitcnt <= '0;
          end
        end
        S_SHIFT: begin
          if (w_period_end) begin
            r_divcnt <= '0;
            if (r_bitcnt == BIT_LAST) begin
              r_bitcnt <= '0;
              r_wcnt   <= r_wcnt + CW'(1);
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
              r_sdata  <= r_shreg[WL-1];
              r_shreg  <= {r_shreg[WL-2:0], 1'b0};
            end
          end else begin
            r_divcnt <= r_divcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_frame_tx.sv
// Directed bench for comm_frame_tx (WL=16, NWORDS=4, DIV=2): basic frame, valid
// gap, enable stall, ignored starts, synchronous clear and asynchronous reset.
module tb_comm_frame_tx;

  localparam int          LIMIT   = 2000;
  localparam logic [63:0] EXP_BITS = 64'hA55A_0001_8000_FFFF;

  logic        iCLK = 1'b0;
  logic        iRST, iCLR, iEN, iSTART, iVALID;
  logic [15:0] iDATA;
  logic        oREADY, oCSn, oSCLK, oSDATA, oBUSY, oDONE;
  logic [2:0]  oWCNT;

  int          n_total = 0;
  int          n_bad   = 0;

  logic [15:0] words [0:7];
  logic [63:0] rx;
  int          n_rise, n_done, cyc, hs_cyc, done_cyc, csn_bad;
  logic        sclk_q = 1'b0;

  comm_frame_tx #(.WL(16), .NWORDS(4), .DIV(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iEN(iEN), .iSTART(iSTART),
    .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY), .oCSn(oCSn),
    .oSCLK(oSCLK), .oSDATA(oSDATA), .oBUSY(oBUSY), .oWCNT(oWCNT), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sampled 1 time unit after each rising edge, when outputs have settled.
  always @(posedge iCLK) begin
    #1;
    cyc++;
    if (oSCLK && !sclk_q) begin
      rx = {rx[62:0], oSDATA};
      n_rise++;
    end
    sclk_q = oSCLK;
    if (oDONE) begin
      n_done++;
      done_cyc = cyc;
    end
    if (hs_cyc < 0 && oREADY) hs_cyc = cyc;
    if (oBUSY && !oDONE && oCSn) csn_bad++;
  end

  task automatic mon_clear();
    rx = '0; n_rise = 0; n_done = 0; cyc = 0; hs_cyc = -1; done_cyc = 0; csn_bad = 0;
  endtask

  // opt bits: 0 valid gap, 1 enable stall, 2 stray starts, 3 clear, 4 reset
  task automatic run_frame(input logic [4:0] opt, output int hi8, output int gap_seen,
                           output logic gap_ok);
    int   pleft = 0, gap_left = 0, cnt;
    logic paused = 0, gap_done = 0, s1 = 0, s2 = 0, clr_pend = 0, hold;
    hi8 = 0; gap_seen = 0; gap_ok = 1'b1;
    mon_clear();
    iVALID = 1'b1;
    iDATA  = words[0];
    iSTART = 1'b1;
    @(negedge iCLK);
    for (cnt = 0; cnt < LIMIT; cnt++) begin
      if (n_done > 0 && !oBUSY) break;
      if (n_rise == 8 && oSCLK) hi8++;
      iSTART = 1'b0;
      if (clr_pend) begin
        iCLR = 1'b0;
        iEN  = 1'b1;
        chk("clr_busy", oBUSY, 0);
        chk("clr_wcnt", oWCNT, 0);
        chk("clr_csn", oCSn, 1);
        chk("clr_sclk", oSCLK, 0);
        break;
      end
      if (pleft > 0) begin
        pleft--;
        if (pleft == 0) iEN = 1'b1;
      end else if (opt[1] && !paused && n_rise == 8 && oSCLK) begin
        paused = 1'b1;
        iEN    = 1'b0;
        pleft  = 5;
      end
      hold = 1'b0;
      if (opt[0] && !gap_done && oWCNT == 3'd2 && oREADY) begin
        gap_done = 1'b1;
        gap_left = 10;
      end
      if (gap_left > 0) begin
        hold  = 1'b1;
        gap_ok = gap_ok && oREADY && !oCSn && !oSCLK;
        gap_left--;
        gap_seen++;
      end
      iVALID = !hold;
      iDATA  = words[oWCNT];
      if (opt[2] && !s1 && oWCNT == 3'd1 && oREADY) begin s1 = 1'b1; iSTART = 1'b1; end
      if (opt[2] && !s2 && n_rise == 40) begin s2 = 1'b1; iSTART = 1'b1; end
      if (opt[3] && n_rise == 37) begin
        iCLR = 1'b1;
        iEN  = 1'b0;
        clr_pend = 1'b1;
      end
      if (opt[4] && n_rise == 1 && oSCLK) begin
        #2 iRST = 1'b1;
        #1;
        chk("arst_csn", oCSn, 1);
        chk("arst_sclk", oSCLK, 0);
        chk("arst_sdata", oSDATA, 0);
        chk("arst_busy", oBUSY, 0);
        chk("arst_ready", oREADY, 0);
        chk("arst_wcnt", oWCNT, 0);
        chk("arst_done", oDONE, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        break;
      end
      @(negedge iCLK);
    end
    chk("frame_timeout", (cnt >= LIMIT), 0);
  endtask

  int   hi8, gap_seen;
  logic gap_ok;

  initial begin
    words[0] = 16'hA55A; words[1] = 16'h0001; words[2] = 16'h8000; words[3] = 16'hFFFF;
    for (int unsigned i = 4; i < 8; i++) words[i] = '0;
    mon_clear();
    iRST = 1'b1; iCLR = 1'b0; iEN = 1'b1; iSTART = 1'b0; iVALID = 1'b1; iDATA = '0;
    repeat (2) @(negedge iCLK);
    chk("rst_csn", oCSn, 1);
    chk("rst_sclk", oSCLK, 0);
    chk("rst_sdata", oSDATA, 0);
    chk("rst_ready", oREADY, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_wcnt", oWCNT, 0);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    run_frame(5'b00000, hi8, gap_seen, gap_ok);
    chk("basic_bits", rx, EXP_BITS);
    chk("basic_rises", n_rise, 64);
    chk("basic_dones", n_done, 1);
    chk("basic_latency", done_cyc - hs_cyc, 260);
    chk("basic_hi_len", hi8, 2);
    chk("basic_csn_cont", csn_bad, 0);
    chk("basic_wcnt_hold", oWCNT, 4);
    chk("basic_idle_csn", oCSn, 1);

    repeat (3) @(negedge iCLK);
    run_frame(5'b00001, hi8, gap_seen, gap_ok);
    chk("gap_cycles", gap_seen, 10);
    chk("gap_levels", gap_ok, 1);
    chk("gap_bits", rx, EXP_BITS);
    chk("gap_dones", n_done, 1);
    chk("gap_csn_cont", csn_bad, 0);

    repeat (3) @(negedge iCLK);
    run_frame(5'b00010, hi8, gap_seen, gap_ok);
    chk("stall_hi_len", hi8, 7);
    chk("stall_bits", rx, EXP_BITS);
    chk("stall_rises", n_rise, 64);

    repeat (3) @(negedge iCLK);
    run_frame(5'b00100, hi8, gap_seen, gap_ok);
    chk("starts_bits", rx, EXP_BITS);
    repeat (20) @(negedge iCLK);
    chk("starts_dones", n_done, 1);
    chk("starts_idle", oBUSY, 0);

    run_frame(5'b01000, hi8, gap_seen, gap_ok);
    repeat (20) @(negedge iCLK);
    chk("clr_no_done", n_done, 0);
    chk("clr_stay_idle", oBUSY, 0);
    run_frame(5'b00000, hi8, gap_seen, gap_ok);
    chk("after_clr_bits", rx, EXP_BITS);
    chk("after_clr_dones", n_done, 1);

    repeat (3) @(negedge iCLK);
    run_frame(5'b10000, hi8, gap_seen, gap_ok);
    chk("arst_no_done", n_done, 0);
    run_frame(5'b00000, hi8, gap_seen, gap_ok);
    chk("after_rst_bits", rx, EXP_BITS);
    chk("after_rst_dones", n_done, 1);
    chk("after_rst_wcnt", oWCNT, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
